// File: rtl/uart_rx_decoder_if.sv
// Parallel-side bundle of the UART receiver: serial line in, decoded byte, strobes and status out.
`timescale 1ns/1ps
interface uart_rx_decoder_if;
    logic        rx;
    logic [7:0]  uart_data;
    logic        uart_data_valid;
    logic        frame_err;
    logic        busy;
    logic [15:0] byte_count;

    modport master (
        output rx,
        input  uart_data, uart_data_valid, frame_err, busy, byte_count
    );

    modport slave (
        input  rx,
        output uart_data, uart_data_valid, frame_err, busy, byte_count
    );
endinterface

// File: rtl/uart_rx_decoder.sv
// 8N1 UART receiver: synchronizes rx, samples each bit mid-period and emits decoded bytes,
// framing-error pulses, a busy flag and a wrapping count of good frames.
`timescale 1ns/1ps
module uart_rx_decoder #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               theclk,
    input  logic               theresetn,
    uart_rx_decoder_if.slave   bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [2:0] S_WAIT_IDLE = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_cpb
            $error("uart_rx_decoder: CLKS_PER_BIT must be >= 4");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("uart_rx_decoder: SYNC_STAGES must be >= 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] settle_q;
    logic                   rxs_s;
    logic                   settled_s;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;
    logic [15:0]   byte_count_q, byte_count_d;

    // Input synchronizer; settle_q marks when the chain holds only post-reset samples of rx,
    // so the idle-reset value of the flops cannot release WAIT_IDLE while rx is held low.
    always_ff @(posedge theclk or negedge theresetn) begin
        if (!theresetn) begin
            sync_q   <= '1;
            settle_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.rx};
            settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rxs_s     = sync_q[SYNC_STAGES-1];
    assign settled_s = settle_q[SYNC_STAGES-1];

    // Frame decoder next-state logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        ferr_d       = 1'b0;
        byte_count_d = byte_count_q;
        case (state_q)
            S_WAIT_IDLE: begin
                if (settled_s && rxs_s) state_d = S_IDLE;
                else                    state_d = S_WAIT_IDLE;
            end
            S_IDLE: begin
                if (!rxs_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rxs_s) begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rxs_s;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs_s) begin
                        state_d      = S_IDLE;
                        data_d       = shift_q;
                        valid_d      = 1'b1;
                        byte_count_d = byte_count_q + 16'd1;
                    end else begin
                        state_d = S_WAIT_IDLE;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_WAIT_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    end

    // Decoder state and registered outputs.
    always_ff @(posedge theclk or negedge theresetn) begin
        if (!theresetn) begin
            state_q      <= S_WAIT_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
            busy_q       <= 1'b0;
            byte_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            ferr_q       <= ferr_d;
            busy_q       <= busy_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign bus.uart_data       = data_q;
    assign bus.uart_data_valid = valid_q;
    assign bus.frame_err       = ferr_q;
    assign bus.busy            = busy_q;
    assign bus.byte_count      = byte_count_q;
endmodule

// File: tb/tb_uart_rx_decoder.sv
// Directed bench for uart_rx_decoder: table of single frames plus hand sequences for
// back-to-back, glitch, break, mid-frame reset and byte-count wrap.
`timescale 1ns/1ps
module tb_uart_rx_decoder;
    localparam int C        = 8;
    localparam int BUSY_CYC = C / 2 + 9 * C;

    logic theclk;
    logic theresetn;
    uart_rx_decoder_if bus();

    uart_rx_decoder #(.CLKS_PER_BIT(C), .SYNC_STAGES(2)) dut (
        .theclk    (theclk),
        .theresetn (theresetn),
        .bus       (bus)
    );

    initial theclk = 1'b0;
    always #5 theclk = ~theclk;

    int n_total = 0;
    int n_pass  = 0;

    int vcnt = 0;
    int fcnt = 0;
    int bcnt = 0;
    int both_cnt = 0;
    logic [7:0] dlog [$];

    logic [7:0]  exp_data  = 8'h00;
    logic [15:0] exp_count = 16'h0000;

    // Event monitor sampled away from the active edge.
    always @(negedge theclk) begin
        if (bus.uart_data_valid) begin
            vcnt <= vcnt + 1;
            dlog.push_back(bus.uart_data);
        end
        if (bus.frame_err) fcnt <= fcnt + 1;
        if (bus.busy) bcnt <= bcnt + 1;
        if (bus.uart_data_valid && bus.frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (C) @(negedge theclk);
    endtask

    task automatic idle_bits(input int n);
        bus.rx = 1'b1;
        repeat (n * C) @(negedge theclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic do_frame(input string name, input logic [7:0] d, input logic stop,
                            input int ev, input int ef);
        int vb, fb, bb;
        vb = vcnt; fb = fcnt; bb = bcnt;
        send_frame(d, stop);
        idle_bits(2);
        if (ev != 0) begin
            exp_data  = d;
            exp_count = exp_count + 16'd1;
        end
        check({name, " valid pulses"}, vcnt - vb, ev);
        check({name, " frame_err pulses"}, fcnt - fb, ef);
        check({name, " busy cycles"}, bcnt - bb, BUSY_CYC);
        check({name, " uart_data"}, bus.uart_data, exp_data);
        check({name, " byte_count"}, bus.byte_count, exp_count);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int vb, fb, lb;
        vecs[0] = '{8'h41, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 0};
        vecs[3] = '{8'h80, 1'b1, 1, 0};
        vecs[4] = '{8'h5A, 1'b0, 0, 1};
        vecs[5] = '{8'h01, 1'b1, 1, 0};

        theresetn = 1'b0;
        bus.rx    = 1'b1;
        repeat (3) @(negedge theclk);
        check("reset uart_data", bus.uart_data, 8'h00);
        check("reset valid", bus.uart_data_valid, 1'b0);
        check("reset frame_err", bus.frame_err, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        check("reset byte_count", bus.byte_count, 16'h0000);
        theresetn = 1'b1;
        idle_bits(2);

        for (int i = 0; i < 6; i++)
            do_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop,
                     vecs[i].exp_valid, vecs[i].exp_ferr);

        // Back-to-back frames with no idle gap.
        vb = vcnt; lb = dlog.size();
        send_frame(8'h48, 1'b1);
        send_frame(8'h69, 1'b1);
        send_frame(8'h0A, 1'b1);
        idle_bits(2);
        exp_count = exp_count + 16'd3;
        exp_data  = 8'h0A;
        check("b2b valid pulses", vcnt - vb, 3);
        if (dlog.size() >= lb + 3) begin
            check("b2b byte0", dlog[lb],     8'h48);
            check("b2b byte1", dlog[lb + 1], 8'h69);
            check("b2b byte2", dlog[lb + 2], 8'h0A);
        end else begin
            check("b2b logged bytes", dlog.size() - lb, 3);
        end
        check("b2b byte_count", bus.byte_count, exp_count);

        // Start-bit glitch shorter than half a bit.
        vb = vcnt; fb = fcnt;
        bus.rx = 1'b0;
        repeat (2) @(negedge theclk);
        idle_bits(2);
        check("glitch valid", vcnt - vb, 0);
        check("glitch frame_err", fcnt - fb, 0);
        check("glitch busy", bus.busy, 1'b0);
        do_frame("after glitch 0x55", 8'h55, 1'b1, 1, 0);

        // Bad stop bit followed by a long break.
        vb = vcnt; fb = fcnt;
        send_frame(8'hA5, 1'b0);
        bus.rx = 1'b0;
        repeat (20 * C) @(negedge theclk);
        check("break frame_err", fcnt - fb, 1);
        check("break valid", vcnt - vb, 0);
        check("break uart_data", bus.uart_data, exp_data);
        check("break byte_count", bus.byte_count, exp_count);
        check("break busy", bus.busy, 1'b0);
        idle_bits(2);
        do_frame("after break 0x3C", 8'h3C, 1'b1, 1, 0);

        // Reset during data bit 4 of 0xFF, released with rx low.
        vb = vcnt; fb = fcnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus.rx = 1'b1;
        repeat (C / 2) @(negedge theclk);
        #2 theresetn = 1'b0;
        #1;
        check("async reset busy", bus.busy, 1'b0);
        check("async reset uart_data", bus.uart_data, 8'h00);
        check("async reset byte_count", bus.byte_count, 16'h0000);
        exp_data  = 8'h00;
        exp_count = 16'h0000;
        bus.rx = 1'b0;
        @(negedge theclk);
        theresetn = 1'b1;
        repeat (3 * C) @(negedge theclk);
        check("held-low valid", vcnt - vb, 0);
        check("held-low frame_err", fcnt - fb, 0);
        check("held-low busy", bus.busy, 1'b0);
        idle_bits(2);
        do_frame("after reset 0x12", 8'h12, 1'b1, 1, 0);

        // Byte counter wrap.
        force dut.byte_count_q = 16'hFFFF;
        @(negedge theclk);
        release dut.byte_count_q;
        @(negedge theclk);
        check("preload byte_count", bus.byte_count, 16'hFFFF);
        exp_count = 16'hFFFF;
        do_frame("wrap 0x7E", 8'h7E, 1'b1, 1, 0);

        check("valid/frame_err overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
